// File: rtl/ble_ctrl_types_pkg.sv
// Shared BLE controller types: TX arbiter FSM states, TX requester indices
// and a helper that sizes index ports safely for a single-entry vector.
package ble_ctrl_types_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } ble_tx_arb_state_t;

    localparam int BLE_TX_REQ_SETUP = 0;
    localparam int BLE_TX_REQ_ERR   = 1;
    localparam int BLE_TX_REQ_XCVR  = 2;

    // A one-entry vector still needs a 1-bit index, $clog2(1) would give 0.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ble_tx_arbiter_rr_arbiter.sv
// Combinational winner select: round-robin from ptr (wrapping) or fixed
// priority with the lowest index winning.
module rr_arbiter
    import ble_ctrl_types_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    input  logic                    rr_mode,
    output logic [idx_w(N_REQ)-1:0] grant_idx,
    output logic                    any_req
);

    localparam int IW = idx_w(N_REQ);

    int          cand;
    logic [IW-1:0] cand_idx;

    // ptr is always < N_REQ, so one subtraction is enough to wrap.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rr_mode ? (int'(ptr) + k) : k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = IW'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req   = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ble_tx_arbiter.sv
// Packet-granular arbiter sharing the UART TX FIFO write port between requesters.
// Optional stall watchdog enabled by defining BLE_TX_ARB_WDOG_EN.
module ble_tx_arbiter
    import ble_ctrl_types_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      rr_mode,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_full,
    output logic                      busy,
    output logic [idx_w(N_REQ)-1:0]   grant_id,
    output logic                      wdog_abort
);

    localparam int IW = idx_w(N_REQ);

    ble_tx_arb_state_t state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     win_idx;
    logic              any_req;
    logic              active;
    logic              g_valid;
    logic              g_last;
    logic              fire;
    logic              wdog_hit;
    logic [DATA_W-1:0] g_data;
    logic [IW-1:0]     next_ptr;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .rr_mode   (rr_mode),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    // Gating with rst drops the grant in the reset cycle itself, so no byte drains.
    always_comb begin
        active  = (state == ARB_XFER) && !rst;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
        fire      = active && g_valid && !tx_full;
        tx_valid  = fire;
        tx_data   = fire ? g_data : '0;
        req_ready = '0;
        if (active && !tx_full) req_ready[grant_id] = 1'b1;
        next_ptr  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (enable && any_req) begin
                        grant_id <= win_idx;
                        busy     <= 1'b1;
                        state    <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if ((fire && g_last) || wdog_hit) begin
                        state  <= ARB_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef BLE_TX_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] stall_cnt;

    // Only cycles with the granted requester silent count; tx_full stalls do not.
    assign wdog_hit = active && !g_valid && (stall_cnt == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= wdog_hit;
            if (state == ARB_IDLE || fire || wdog_hit) begin
                stall_cnt <= '0;
            end else if (!g_valid) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end
`else
    assign wdog_hit   = 1'b0;
    assign wdog_abort = 1'b0;
`endif

endmodule

// File: tb/tb_ble_tx_arbiter.sv
// Scoreboard bench for ble_tx_arbiter: requester queues feed the DUT, and a
// negedge monitor pops the expected {grant, byte} stream on every TX write.
module tb_ble_tx_arbiter;
    import ble_ctrl_types_pkg::*;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int IW = 2;
`ifdef BLE_TX_ARB_WDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 1024;
`endif

    logic            clk;
    logic            rst;
    logic            enable;
    logic            rr_mode;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_full;
    logic            busy;
    logic [IW-1:0]   grant_id;
    logic            wdog_abort;

    ble_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .WDOG_CYCLES(WD)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rr_mode    (rr_mode),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .busy       (busy),
        .grant_id   (grant_id),
        .wdog_abort (wdog_abort)
    );

    // Clock and global time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required to end before 200000");
        $fatal(1);
    end

    // Scoreboard state and requester models
    logic [IW+DW-1:0] exp_q[$];
    logic [DW:0]      src_q[N][$];
    logic [N-1:0]     acc;
    logic [N-1:0]     hold;
    logic [IW+DW-1:0] mon_e;
    logic [DW:0]      head;
    int               n_tests;
    int               n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples handshakes and TX writes away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) acc[i] = 1'b1;
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got id %0d data 0x%02h, expected no write", grant_id, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_byte", {22'd0, grant_id, tx_data}, {22'd0, mon_e});
                check("sb_ready", {29'd0, req_ready}, 32'd1 << mon_e[DW +: IW]);
            end
        end
    end

    // Driver: each requester presents the head of its queue until accepted.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            acc[i] = 1'b0;
            if (src_q[i].size() > 0 && !hold[i]) begin
                head = src_q[i][0];
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = head[DW-1:0];
                req_last[i]           = head[DW];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int r, input logic [DW-1:0] b0, input int len, input bit do_exp);
        logic [DW-1:0] b;
        for (int k = 0; k < len; k++) begin
            b = b0 + DW'(k);
            src_q[r].push_back({(k == len - 1), b});
            if (do_exp) exp_q.push_back({IW'(r), b});
        end
    endtask

    // mode 0: wait for tx_valid, 1: wait for busy, 2: wait for all expected bytes and idle
    task automatic wait_for(input string name, input int mode, input int max);
        bit seen;
        seen = 1'b0;
        repeat (max) begin
            @(negedge clk);
            if ((mode == 0 && tx_valid) || (mode == 1 && busy) ||
                (mode == 2 && !busy && exp_q.size() == 0)) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: condition not reached in %0d cycles, required within bound", name, max);
        end
    endtask

    // Main stimulus
    int pulses;
    initial begin
        n_tests = 0; n_fail = 0;
        acc = '0; hold = '0;
        rst = 1'b1; enable = 1'b0; rr_mode = 1'b0; tx_full = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_wdog_abort", wdog_abort, 0);

        // Single packet on requester 1, pending first with enable low
        push_pkt(1, 8'h01, 3, 1);
        repeat (3) tick();
        @(negedge clk);
        check("en0_no_grant_busy", busy, 0);
        check("en0_no_grant_ready", req_ready, 0);
        tick();
        enable = 1'b1;
        @(negedge clk);
        check("t1_arb_cycle_busy", busy, 0);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_grant_id", grant_id, 1);
        check("t1_byte0_valid", tx_valid, 1);
        @(negedge clk);
        check("t1_byte1_data", tx_data, 8'h02);
        @(negedge clk);
        check("t1_byte2_data", tx_data, 8'h03);
        @(negedge clk);
        check("t1_end_busy", busy, 0);
        wait_for("t1_done", 2, 20);

        // Fixed-priority contention between requesters 0 and 2
        enable = 1'b0;
        push_pkt(0, 8'h10, 2, 1);
        push_pkt(2, 8'h20, 2, 1);
        repeat (2) tick();
        enable = 1'b1;
        wait_for("t2_done", 2, 40);

        // Enable low with a pending request, then enable dropped mid-packet
        tick();
        enable = 1'b0;
        push_pkt(2, 8'h60, 3, 1);
        repeat (2) tick();
        repeat (4) begin
            @(negedge clk);
            check("en0_pending_busy", busy, 0);
            check("en0_pending_tx_valid", tx_valid, 0);
        end
        tick();
        enable = 1'b1;
        wait_for("t5_grant", 1, 10);
        check("t5_grant_id", grant_id, 2);
        tick();
        enable = 1'b0;
        push_pkt(0, 8'h70, 1, 0);
        wait_for("t5_done", 2, 30);
        repeat (5) begin
            @(negedge clk);
            check("t5_no_regrant_busy", busy, 0);
        end
        tick();
        src_q[0].delete();
        repeat (2) tick();

        // Backpressure: tx_full for 4 cycles after the first byte
        push_pkt(1, 8'hA1, 3, 1);
        repeat (2) tick();
        enable = 1'b1;
        wait_for("t4_first", 0, 10);
        tick();
        tx_full = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t4_full_tx_valid", tx_valid, 0);
            check("t4_full_req_ready", req_ready, 0);
            check("t4_full_busy", busy, 1);
            check("t4_full_grant_id", grant_id, 1);
        end
        tick();
        tx_full = 1'b0;
        wait_for("t4_done", 2, 20);

        // Reset mid-packet on requester 1 (rr pointer is 2 before this)
        enable = 1'b0;
        push_pkt(1, 8'h50, 4, 0);
        exp_q.push_back({2'd1, 8'h50});
        repeat (2) tick();
        enable = 1'b1;
        wait_for("t5r_first", 0, 10);
        tick();
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("t5r_rst_tx_valid", tx_valid, 0);
        check("t5r_rst_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        src_q[1].delete();
        @(negedge clk);
        check("t5r_busy", busy, 0);
        check("t5r_grant_id", grant_id, 0);
        repeat (2) tick();

        // Round-robin from a freshly reset pointer: expect 0,1,2,0,1,2
        rr_mode = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++)
                push_pkt(r, DW'(8'h30 + 16 * p + r), 1, 1);
        repeat (2) tick();
        enable = 1'b1;
        wait_for("t3_done", 2, 60);

`ifdef BLE_TX_ARB_WDOG_EN
        // Watchdog: requester 1 goes silent after its first byte
        enable = 1'b0;
        rr_mode = 1'b0;
        repeat (2) tick();
        push_pkt(1, 8'h80, 3, 0);
        exp_q.push_back({2'd1, 8'h80});
        push_pkt(2, 8'h90, 1, 1);
        repeat (2) tick();
        enable = 1'b1;
        wait_for("t6_first", 0, 10);
        tick();
        hold[1] = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (wdog_abort) pulses++;
        end
        check("t6_wdog_pulses", pulses, 1);
        wait_for("t6_done", 2, 20);
        src_q[1].delete();
        hold[1] = 1'b0;
`else
        pulses = 0;
`endif

        repeat (3) tick();
        check("final_exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_tx_arbiter.md
Name: ble_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port (tx_valid/tx_data/tx_full) between several byte-stream requesters: the setup command sender, the controller's error reporter and the transceiver datapath.
- Arbitrates at packet granularity, so a granted requester keeps the port until its last byte is accepted.
- Sits between the BLE setup/controller blocks and the UART TX FIFO, and replaces the ad-hoc TX muxing.

Parameters:
- N_REQ, 3, number of requesters; index 0 is the highest fixed priority.
- DATA_W, 8, byte width.
- WDOG_CYCLES, 1024, stall limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- enable  in  1  allows new grants when high; a packet already in flight always completes.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins).
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  out  N_REQ  per-requester byte accepted.
- tx_valid  out  1  write strobe to the UART TX FIFO.
- tx_data  out  DATA_W  byte to the FIFO.
- tx_full  in  1  FIFO full; no write is allowed while high.
- busy  out  1  a grant is held.
- grant_id  out  $clog2(N_REQ)  index of the current grant; valid only while busy.
- wdog_abort  out  1  one-cycle pulse when a stalled packet is aborted; tied to 0 without the optional feature.

Behaviour:
- Reset values: state=IDLE, busy=0, grant_id=0, rr_ptr=0, req_ready=0, tx_valid=0, tx_data=0, wdog_abort=0. A reset mid-packet drops the grant immediately and does not drain bytes.
- FSM has two states, IDLE and XFER.
- IDLE:
  - Entered when enable=1 and any req_valid is high.
  - Winner is chosen combinationally and registered into grant_id. busy=1 and state=XFER from the next cycle, giving 1 cycle of arbitration latency.
  - If enable=0, stays in IDLE and all outputs are 0.
- Round-robin: search starts at rr_ptr and wraps modulo N_REQ. At packet end, rr_ptr = grant_id+1, wrapping N_REQ-1 -> 0.
- Fixed priority: rr_ptr is ignored.
- XFER datapath is combinational pass-through:
  - tx_valid = req_valid[g] & ~tx_full.
  - tx_data = req_data[g]; tx_data = 0 when tx_valid=0.
  - req_ready[g] = ~tx_full; every other req_ready = 0.
  - A byte transfers in any cycle where req_valid[g] & req_ready[g].
- Packet end: when a transferred byte has req_last[g]=1, go to IDLE next cycle, with busy=0 and rr_ptr updated. This leaves at least 1 idle cycle between packets.
- tx_full=1: tx_valid=0, the byte is held by the requester, and the grant is kept.
- req_valid[g] dropping mid-packet is legal; the grant is kept.
- req_last without req_valid is ignored.
- Simultaneous requests on the same cycle: only the winner is granted. Losers see req_ready=0 and must hold their data.
- enable falling during XFER has no effect until packet end; no new grant is issued afterwards.
- N_REQ=1: arbitration trivially selects index 0, and rr_ptr stays at 0.

Optional Feature:
- Macro: BLE_TX_ARB_WDOG_EN.
- Defined:
  - A stall counter counts XFER cycles with req_valid[g]=0. It clears on every transferred byte and on entering XFER.
  - Cycles stalled only by tx_full are not counted.
  - When the counter reaches WDOG_CYCLES: force IDLE, pulse wdog_abort for 1 cycle, and advance rr_ptr as at a normal packet end.
- Undefined: no counter logic is built, and wdog_abort is tied to 0.

Decomposition:
- ble_ctrl_types_pkg gains:
  - the enum ble_tx_arb_state_t {ARB_IDLE, ARB_XFER};
  - the localparam BLE_TX_REQ_SETUP=0, BLE_TX_REQ_ERR=1, BLE_TX_REQ_XCVR=2 index constants.
- One sub-module: rr_arbiter, a combinational request vector + pointer + mode -> one-hot/index winner with any_req.

Test Plan:
1. Single packet, no contention: req_valid[1]=1 with 3 bytes 0x01,0x02,0x03, last on 0x03 -> busy on the next cycle, grant_id=1, tx_data 01/02/03 on consecutive cycles, then busy=0.
2. Contention, rr_mode=0: req 0 and req 2 both valid, 2-byte packets -> req 0 is served first, req 2 after 1 idle cycle, with no byte interleaving.
3. Round-robin, rr_mode=1: all 3 requesters continuously sending 1-byte packets -> grant order 0,1,2,0,1,2. rr_ptr wraps 2 -> 0.
4. Backpressure: tx_full=1 for 4 cycles mid-packet -> tx_valid=0 and req_ready=0 throughout. The byte resumes unchanged with no loss or duplication, and the grant is held.
5. Reset and enable: rst=1 asserted mid-packet -> next cycle busy=0, rr_ptr=0. With enable=0 and a request pending -> no grant. Deasserting enable mid-packet -> the packet completes, then no further grant.
6. With BLE_TX_ARB_WDOG_EN and WDOG_CYCLES=8: the granted requester drops req_valid after byte 1 -> wdog_abort pulses once on the stall cycle equal to WDOG_CYCLES, then busy=0 and the next requester is granted.
